// File: rtl/rv_core_pkg.sv
// Shared definitions for the execute sequencer: opcodes, FSM encoding, PC step.
package rv_core_pkg;

  localparam logic [6:0]  OP_REG  = 7'b0110011;
  localparam logic [6:0]  OP_IMM  = 7'b0010011;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_WRITEBACK = 3'd3,
    ST_TRAP      = 3'd4
  } state_t;

  // Only register-register and register-immediate ALU ops are executable.
  function automatic logic is_legal_op(input logic [6:0] op);
    return (op == OP_REG) || (op == OP_IMM);
  endfunction

endpackage

// File: rtl/rv_latency_counter.sv
// 4-bit down-counter timing the ALU latency window; done when it reaches 1.
module rv_latency_counter (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic       dec_i,
  input  logic [3:0] load_val_i,
  output logic       done_o
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  // Load takes priority; decrement saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == 4'd1);

endmodule

// File: rtl/rv_exec_sequencer.sv
// Single-issue execute sequencer: accept, decode, wait on the ALU, write back.
module rv_exec_sequencer
  import rv_core_pkg::*;
#(
  parameter int          ALU_LATENCY = 2,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic [31:0] pc,
  output logic [4:0]  rf_rs1_addr,
  output logic [4:0]  rf_rs2_addr,
  output logic [31:0] alu_instruction,
  output logic        alu_register_type,
  output logic        alu_immediate_type,
  input  logic [31:0] alu_result,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        retire,
  output logic        trap
);

  localparam logic [3:0] LAT_LOAD = ALU_LATENCY[3:0];

  state_t      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q,    pc_d;
  logic        cnt_load;
  logic        cnt_dec;
  logic        cnt_done;

  rv_latency_counter u_lat_cnt (
    .clk_i      (clock),
    .rst_ni     (reset_n),
    .load_i     (cnt_load),
    .dec_i      (cnt_dec),
    .load_val_i (LAT_LOAD),
    .done_o     (cnt_done)
  );

  // Next-state logic; the instruction word is only captured in IDLE.
  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    pc_d     = pc_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          instr_d = instr;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (is_legal_op(instr_q[6:0])) begin
          cnt_load = 1'b1;
          state_d  = ST_EXECUTE;
        end else begin
          state_d  = ST_TRAP;
        end
      end
      ST_EXECUTE: begin
        if (cnt_done) begin
          state_d = ST_WRITEBACK;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_WRITEBACK: begin
        pc_d    = pc_q + PC_STEP;
        state_d = ST_IDLE;
      end
      ST_TRAP: begin
        state_d = ST_TRAP;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, latched instruction and PC; reset discards any in-flight work.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      instr_q <= 32'd0;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign instr_ready        = (state_q == ST_IDLE) && reset_n;
  assign pc                 = pc_q;
  assign rf_rs1_addr        = instr_q[19:15];
  assign rf_rs2_addr        = instr_q[24:20];
  assign alu_instruction    = instr_q;
  assign alu_register_type  = (state_q == ST_EXECUTE) && (instr_q[6:0] == OP_REG);
  assign alu_immediate_type = (state_q == ST_EXECUTE) && (instr_q[6:0] == OP_IMM);
  assign rf_waddr           = instr_q[11:7];
  assign rf_wdata           = alu_result;
  assign rf_we              = (state_q == ST_WRITEBACK) && (instr_q[11:7] != 5'd0);
  assign retire             = (state_q == ST_WRITEBACK);
  assign trap               = (state_q == ST_TRAP);

endmodule

// File: tb/tb_rv_exec_sequencer.sv
// Directed bench for rv_exec_sequencer: table of single instructions plus
// hand-written sequences for latency 3, PC wrap and reset mid-EXECUTE.
module tb_rv_exec_sequencer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = 32'd0;
  logic [31:0] alu_result = 32'd0;

  // Instance A: defaults. B: ALU_LATENCY=3. C: RESET_PC near wrap.
  logic        a_ready, a_reg, a_imm, a_we, a_retire, a_trap;
  logic [31:0] a_pc, a_ainstr, a_wdata;
  logic [4:0]  a_rs1, a_rs2, a_waddr;
  logic        b_ready, b_reg, b_imm, b_we, b_retire, b_trap;
  logic [31:0] b_pc, b_ainstr, b_wdata;
  logic [4:0]  b_rs1, b_rs2, b_waddr;
  logic        c_ready, c_reg, c_imm, c_we, c_retire, c_trap;
  logic [31:0] c_pc, c_ainstr, c_wdata;
  logic [4:0]  c_rs1, c_rs2, c_waddr;

  rv_exec_sequencer dut_a (
    .clock(clock), .reset_n(reset_n), .instr_valid(instr_valid), .instr_ready(a_ready),
    .instr(instr), .pc(a_pc), .rf_rs1_addr(a_rs1), .rf_rs2_addr(a_rs2),
    .alu_instruction(a_ainstr), .alu_register_type(a_reg), .alu_immediate_type(a_imm),
    .alu_result(alu_result), .rf_we(a_we), .rf_waddr(a_waddr), .rf_wdata(a_wdata),
    .retire(a_retire), .trap(a_trap));

  rv_exec_sequencer #(.ALU_LATENCY(3)) dut_b (
    .clock(clock), .reset_n(reset_n), .instr_valid(instr_valid), .instr_ready(b_ready),
    .instr(instr), .pc(b_pc), .rf_rs1_addr(b_rs1), .rf_rs2_addr(b_rs2),
    .alu_instruction(b_ainstr), .alu_register_type(b_reg), .alu_immediate_type(b_imm),
    .alu_result(alu_result), .rf_we(b_we), .rf_waddr(b_waddr), .rf_wdata(b_wdata),
    .retire(b_retire), .trap(b_trap));

  rv_exec_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dut_c (
    .clock(clock), .reset_n(reset_n), .instr_valid(instr_valid), .instr_ready(c_ready),
    .instr(instr), .pc(c_pc), .rf_rs1_addr(c_rs1), .rf_rs2_addr(c_rs2),
    .alu_instruction(c_ainstr), .alu_register_type(c_reg), .alu_immediate_type(c_imm),
    .alu_result(alu_result), .rf_we(c_we), .rf_waddr(c_waddr), .rf_wdata(c_wdata),
    .retire(c_retire), .trap(c_trap));

  always #5 clock = ~clock;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] alu;
    int          kind;   // 0 register, 1 immediate, 2 illegal
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        we;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    instr_valid = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    #1;
  endtask

  // Offer one instruction for a single cycle, then scramble the bus.
  task automatic accept(input logic [31:0] w, input logic [31:0] res);
    instr       = w;
    alu_result  = res;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    instr       = 32'hFFFF_FFFF;
  endtask

  initial begin
    int reg_n, imm_n, ret_n, bad;

    vecs[0] = '{32'h0020_81B3, 32'd7,          0, 5'd1, 5'd2, 5'd3, 1'b1};
    vecs[1] = '{32'h0050_0093, 32'd5,          1, 5'd0, 5'd5, 5'd1, 1'b1};
    vecs[2] = '{32'h0000_0013, 32'h0000_0123,  1, 5'd0, 5'd0, 5'd0, 1'b0};
    vecs[3] = '{32'h0031_0233, 32'hDEAD_BEEF,  0, 5'd2, 5'd3, 5'd4, 1'b1};
    vecs[4] = '{32'h0000_006F, 32'd9,          2, 5'd0, 5'd0, 5'd0, 1'b0};
    vecs[5] = '{32'h0000_0003, 32'd9,          2, 5'd0, 5'd0, 5'd0, 1'b0};

    // Ready must stay low while reset is asserted.
    reset_n = 1'b0;
    tick();
    chk("ready_in_reset", {31'd0, a_ready}, 32'd0);

    for (int i = 0; i < 6; i++) begin
      do_reset();
      chk($sformatf("v%0d_rst_ready", i), {31'd0, a_ready}, 32'd1);
      chk($sformatf("v%0d_rst_pc", i), a_pc, 32'd0);
      chk($sformatf("v%0d_rst_flags", i), {29'd0, a_trap, a_we, a_retire}, 32'd0);
      accept(vecs[i].instr, vecs[i].alu);
      reg_n = 0; imm_n = 0; ret_n = 0;
      for (int c = 1; c <= 5; c++) begin
        if (a_reg)    reg_n++;
        if (a_imm)    imm_n++;
        if (a_retire) ret_n++;
        if (c == 1) begin
          chk($sformatf("v%0d_rs1", i), {27'd0, a_rs1}, {27'd0, vecs[i].rs1});
          chk($sformatf("v%0d_rs2", i), {27'd0, a_rs2}, {27'd0, vecs[i].rs2});
          chk($sformatf("v%0d_dec_ready_trap", i), {30'd0, a_ready, a_trap}, 32'd0);
        end
        if (c == 2 && vecs[i].kind == 2) begin
          chk($sformatf("v%0d_trap_set", i), {30'd0, a_trap, a_ready}, 32'd2);
        end
        if (c == 4 && vecs[i].kind != 2) begin
          chk($sformatf("v%0d_wb_we", i), {31'd0, a_we}, {31'd0, vecs[i].we});
          chk($sformatf("v%0d_wb_retire", i), {31'd0, a_retire}, 32'd1);
          chk($sformatf("v%0d_wb_waddr", i), {27'd0, a_waddr}, {27'd0, vecs[i].rd});
          chk($sformatf("v%0d_wb_wdata", i), a_wdata, vecs[i].alu);
        end
        tick();
      end
      chk($sformatf("v%0d_reg_cycles", i), reg_n, (vecs[i].kind == 0) ? 2 : 0);
      chk($sformatf("v%0d_imm_cycles", i), imm_n, (vecs[i].kind == 1) ? 2 : 0);
      chk($sformatf("v%0d_retires", i), ret_n, (vecs[i].kind == 2) ? 0 : 1);
      chk($sformatf("v%0d_pc_after", i), a_pc, (vecs[i].kind == 2) ? 32'd0 : 32'd4);
      if (vecs[i].kind == 2) begin
        bad = 0;
        for (int c = 0; c < 20; c++) begin
          if (a_pc !== 32'd0 || a_ready || a_we || a_retire || !a_trap) bad++;
          tick();
        end
        chk($sformatf("v%0d_trap_hold", i), bad, 0);
      end
    end

    // ALU_LATENCY=3 timing on B; PC wrap on C (latency 2) from the same stimulus.
    do_reset();
    chk("b_rst_pc", b_pc, 32'd0);
    chk("c_rst_pc", c_pc, 32'hFFFF_FFFC);
    accept(32'h0050_0093, 32'd5);
    imm_n = 0;
    for (int c = 1; c <= 6; c++) begin
      if (b_imm) imm_n++;
      if (c == 4) begin
        chk("b_no_retire_early", {31'd0, b_retire}, 32'd0);
        chk("c_retire_at4", {31'd0, c_retire}, 32'd1);
      end
      if (c == 5) begin
        chk("b_wb_we_retire", {30'd0, b_we, b_retire}, 32'd3);
        chk("b_wb_waddr", {27'd0, b_waddr}, 32'd1);
      end
      tick();
    end
    chk("b_imm_cycles", imm_n, 3);
    chk("b_pc_after", b_pc, 32'd4);
    chk("c_pc_wrap", c_pc, 32'd0);

    // Reset during the second EXECUTE cycle of a second instruction.
    do_reset();
    accept(32'h0020_81B3, 32'd7);
    for (int c = 0; c < 5; c++) tick();
    chk("mid_pc_before", a_pc, 32'd4);
    accept(32'h0020_81B3, 32'd7);
    tick();
    tick();
    chk("mid_in_execute", {31'd0, a_reg}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_ready_low", {31'd0, a_ready}, 32'd0);
    tick();
    chk("mid_rst_pc", a_pc, 32'd0);
    chk("mid_rst_flags", {29'd0, a_we, a_retire, a_reg}, 32'd0);
    reset_n = 1'b1;
    #1;
    chk("mid_ready_after", {31'd0, a_ready}, 32'd1);
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      if (a_we || a_retire || !a_ready || a_pc !== 32'd0) bad++;
      tick();
    end
    chk("mid_no_writeback", bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
